count_ones_ctrl: RTL
====================

# count_ones_ctrl

Host-side initiator for the serial ones-counter (`start`/`done`/`bit_count` interface). It accepts data words over a valid/ready input channel and launches one counter operation per word. It waits for the counter's `done`, with a timeout, and returns the count, or an error, over a valid/ready result channel. It sits between the datapath producer and the ones-counter, and owns all sequencing of that counter.

## Interface
- `data_width`, 4, width of data word; must match the counter.
- `count_width`, 3, width of count; must satisfy 2^count_width > data_width.
- `timeout_cycles`, 8, WAIT edges without `done` before error; must be > data_width+1.
- `tmo_width`, 4, timeout counter width; must satisfy 2^tmo_width ≥ timeout_cycles.

Ports:
- `clk`  in  1  sole clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-low (0 = reset asserted).
- `in_valid`  in  1  producer offers `in_data`.
- `in_ready`  out  1  controller can accept a word.
- `in_data`  in  data_width  word to count.
- `start`  out  1  one-cycle launch pulse to the counter.
- `data`  out  data_width  word presented to the counter; held stable from acceptance until next acceptance.
- `abort`  out  1  one-cycle pulse to the counter's synchronous reset on timeout.
- `done`  in  1  counter completion level.
- `bit_count`  in  count_width  counter result.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer takes result.
- `res_count`  out  count_width  captured count (0 on error).
- `res_error`  out  1  1 = timeout, no valid count.
- `busy`  out  1  1 in any state except IDLE.

## Operation
- All outputs are registered. Reset values: `in_ready`=0, `start`=0, `abort`=0, `data`=0, `res_valid`=0, `res_count`=0, `res_error`=0, `busy`=0, state=IDLE, timeout counter=0.
- FSM states are IDLE, LAUNCH, WAIT and HOLD.
- **IDLE:** `in_ready`=1, from the first edge after reset release.
  - On an edge with `in_valid`&`in_ready`: latch `in_data` into `data`, drop `in_ready`, go to LAUNCH.
  - `done` is ignored; it may be stale high from the previous operation.
- **LAUNCH:** `start`=1 for exactly this one cycle. `done` is ignored. Clear the timeout counter. Go to WAIT.
- **WAIT:** `done` is sampled on every edge.
  - `done`=1: capture `bit_count` into `res_count`, set `res_error`=0, go to HOLD.
  - `done`=0 and timeout counter = timeout_cycles−1: set `res_count`=0, `res_error`=1, pulse `abort` for one cycle, go to HOLD.
  - Otherwise: increment the timeout counter.
  - If `done` and the timeout condition occur on the same edge, `done` wins.
- **HOLD:** `res_valid`=1. `res_count` and `res_error` are stable while `res_ready`=0.
  - On an edge with `res_ready`=1: `res_valid`←0, `in_ready`←1, go to IDLE.
  - `in_valid` is ignored.
- `reset` asserted in any state forces the reset values immediately, without waiting for `clk`. Any operation in flight is dropped, and no partial result is presented.
- `data` changes only on input acceptance; the counter may sample it on any cycle after `start`.

## Timing
- Let acceptance be edge 0.
  - `start` is high during cycle 0→1.
  - The counter samples `start` at edge 1.
  - The counter raises `done` after edge data_width+2.
  - The controller captures it at edge data_width+3, and `res_valid` is high after that edge. With defaults, this is edge 7.
- Timeout: `res_valid`/`res_error` are high after edge timeout_cycles+1 (edge 9 with defaults). `abort` is high for the same first HOLD cycle only.
- Minimum initiation interval is data_width+5 edges when `res_ready` is held 1: accept → LAUNCH → WAIT… → HOLD → IDLE → accept.
- `start` is never asserted again before the current result has been consumed.

## Test plan
- **Reset values:** hold `reset`=0 for 3 cycles → all outputs 0. Release → `in_ready`=1 after the first edge.
- **Single operation:** `in_data`=4'b1011, `res_ready`=1 → `start` pulses one cycle after acceptance; `res_valid`=1, `res_count`=3, `res_error`=0 after edge 7.
- **Extremes, back-to-back:** words 4'h0 then 4'hF with `in_valid` held and `res_ready`=1 → results 0 then 4. The second `start` occurs exactly one initiation interval (9 edges) after the first.
- **Back-pressure:** `res_ready`=0 for 5 cycles after `res_valid` → `res_count`/`res_error` stable, `in_ready`=0, no new `start`. Raising `res_ready` → IDLE on the next edge.
- **Timeout:** `done` tied 0 → `res_error`=1, `res_count`=0, `res_valid` after edge 9, one-cycle `abort`. A `done`=1 injected at the timeout edge → normal result, `res_error`=0, no `abort`.
- **Reset mid-operation:** assert `reset` in the middle of WAIT (between edges 3 and 4) → outputs clear without a clock edge. After release, a new word 4'b0110 → `res_count`=2 with normal latency.

Source files
------------

// File: rtl/count_ones_ctrl.sv
// Host-side initiator for the serial ones-counter: accept a word, launch the count, return result or timeout.
// Latency: result valid data_width+3 edges after acceptance; on timeout, timeout_cycles+1 edges after.
// Backpressure: in_ready_o low from acceptance until the result is consumed; the result holds while res_ready_i is low.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   in_valid_i/in_ready_o/in_data_i    word input channel (valid/ready)
//   start_o, data_o, abort_o      launch pulse, held word, and abort pulse to the counter
//   done_i, bit_count_i           completion level and result from the counter
//   res_valid_o/res_ready_i       result channel (valid/ready)
//   res_count_o, res_error_o      captured count (0 on error) and timeout flag
//   busy_o                        high whenever an operation is in flight
module count_ones_ctrl #(
  parameter int DATA_WIDTH     = 4,
  parameter int COUNT_WIDTH    = 3,
  parameter int TIMEOUT_CYCLES = 8,
  parameter int TMO_WIDTH      = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DATA_WIDTH-1:0]  in_data_i,
  output logic                   start_o,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   abort_o,
  input  logic                   done_i,
  input  logic [COUNT_WIDTH-1:0] bit_count_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [COUNT_WIDTH-1:0] res_count_o,
  output logic                   res_error_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_e;

  localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                 state_q;
  logic [TMO_WIDTH-1:0]   tmo_q;
  logic                   in_ready_q;
  logic                   start_q;
  logic                   abort_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   res_valid_q;
  logic [COUNT_WIDTH-1:0] res_count_q;
  logic                   res_error_q;
  logic                   busy_q;

  logic tmo_hit;
  assign tmo_hit = (tmo_q == TMO_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      in_ready_q  <= 1'b0;
      start_q     <= 1'b0;
      abort_q     <= 1'b0;
      data_q      <= '0;
      res_valid_q <= 1'b0;
      res_count_q <= '0;
      res_error_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // start and abort are single-cycle pulses; they fall on the edge after they rise.
      start_q <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // done_i may still be high from the previous operation; it is not looked at here.
          if (in_valid_i && in_ready_q) begin
            data_q     <= in_data_i;
            in_ready_q <= 1'b0;
            start_q    <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= LAUNCH;
          end else begin
            // First edge after reset release raises in_ready.
            in_ready_q <= 1'b1;
          end
        end
        LAUNCH: begin
          // The counter samples start on this edge, so done_i is still stale here.
          tmo_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // done is checked first so it wins over a simultaneous timeout.
          if (done_i) begin
            res_count_q <= bit_count_i;
            res_error_q <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else if (tmo_hit) begin
            res_count_q <= '0;
            res_error_q <= 1'b1;
            res_valid_q <= 1'b1;
            abort_q     <= 1'b1;
            state_q     <= HOLD;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        HOLD: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign start_o     = start_q;
  assign abort_o     = abort_q;
  assign data_o      = data_q;
  assign res_valid_o = res_valid_q;
  assign res_count_o = res_count_q;
  assign res_error_o = res_error_q;
  assign busy_o      = busy_q;

endmodule
